// File: rtl/dsp_mac_sequencer.sv
// Multiply-accumulate sequencer for one DSP48A1 slice. It issues operands and a per-cycle OPMODE,
// follows the slice pipeline with a tag shift register, and buffers one result per N_TAPS pairs.
module dsp_mac_sequencer #(
  parameter int unsigned N_TAPS     = 8,
  parameter int unsigned P_LAT      = 3,
  parameter int unsigned OPMODE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  input  logic [47:0] dsp_p,
  input  logic        dsp_carry_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic        out_ovf
);

  localparam int unsigned TapW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [TapW-1:0] LastTap = TapW'(N_TAPS - 1);
  localparam logic [7:0] OpLoad = 8'h01;  // P = M
  localparam logic [7:0] OpAcc  = 8'h09;  // P = P + M
  localparam logic [7:0] OpHold = 8'h08;  // P = P

  logic                     accept, is_last, last_in_flight;
  logic                     exit_vld, exit_last, load, pop;
  logic [TapW-1:0]          tap_q, tap_d;
  logic [17:0]              dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d;
  logic                     issue_vld_q, issue_vld_d, issue_last_q, issue_last_d;
  logic [P_LAT-1:0]         tag_vld_q, tag_vld_d, tag_last_q, tag_last_d;
  logic [OPMODE_DLY:0][7:0] op_line_q, op_line_d;
  logic                     sticky_q, sticky_d;
  logic                     out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic [47:0]              out_data_q, out_data_d;

  assign is_last        = (tap_q == LastTap);
  // Only one last tag may be in flight, so a result always lands in a free (or popping) buffer.
  assign last_in_flight = (issue_vld_q && issue_last_q) || (|(tag_vld_q & tag_last_q));
  assign in_ready       = !is_last || (!last_in_flight && (!out_valid_q || out_ready));
  assign accept         = in_valid && in_ready;

  assign exit_vld  = tag_vld_q[P_LAT-1];
  assign exit_last = tag_last_q[P_LAT-1];
  assign load      = exit_vld && exit_last;
  assign pop       = out_valid_q && out_ready;

  always_comb begin
    tap_d        = tap_q;
    dsp_a_d      = dsp_a_q;
    dsp_b_d      = dsp_b_q;
    issue_vld_d  = accept;
    issue_last_d = accept && is_last;
    if (accept) begin
      dsp_a_d = in_a;
      dsp_b_d = in_b;
      tap_d   = is_last ? '0 : tap_q + TapW'(1);
    end

    // Stage 0 is aligned with dsp_a/dsp_b; the slice sees the code OPMODE_DLY cycles later.
    op_line_d    = op_line_q;
    op_line_d[0] = !accept ? OpHold : ((tap_q == '0) ? OpLoad : OpAcc);
    for (int i = 1; i <= OPMODE_DLY; i++) begin
      op_line_d[i] = op_line_q[i-1];
    end

    tag_vld_d     = tag_vld_q;
    tag_last_d    = tag_last_q;
    tag_vld_d[0]  = issue_vld_q;
    tag_last_d[0] = issue_last_q;
    for (int i = 1; i < P_LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end

    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (exit_vld) begin
      sticky_d = exit_last ? 1'b0 : (sticky_q | dsp_carry_out);
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = dsp_p;
      out_ovf_d   = sticky_q | dsp_carry_out;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q        <= '0;
      dsp_a_q      <= '0;
      dsp_b_q      <= '0;
      issue_vld_q  <= 1'b0;
      issue_last_q <= 1'b0;
      tag_vld_q    <= '0;
      tag_last_q   <= '0;
      op_line_q    <= '0;
      sticky_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      tap_q        <= tap_d;
      dsp_a_q      <= dsp_a_d;
      dsp_b_q      <= dsp_b_d;
      issue_vld_q  <= issue_vld_d;
      issue_last_q <= issue_last_d;
      tag_vld_q    <= tag_vld_d;
      tag_last_q   <= tag_last_d;
      op_line_q    <= op_line_d;
      sticky_q     <= sticky_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign dsp_a      = dsp_a_q;
  assign dsp_b      = dsp_b_q;
  assign dsp_opmode = op_line_q[OPMODE_DLY];
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: three instances (N_TAPS 4, 1, 1024), each with a behavioural slice,
// checked against a dot-product reference model and an OPMODE-per-cycle model.
module tb_dsp_mac_sequencer;

  localparam int NI = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [17:0] in_a      [NI];
  logic [17:0] in_b      [NI];
  logic [17:0] dsp_a     [NI];
  logic [17:0] dsp_b     [NI];
  logic [7:0]  dsp_op    [NI];
  logic [47:0] dsp_p     [NI];
  logic        dsp_cout  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [47:0] out_data  [NI];
  logic        out_ovf   [NI];
  logic        pre_en    [NI];
  logic        op_force  [NI];
  logic [47:0] pre_val;

  int n_cmp  = 0;
  int n_fail = 0;
  int last_wait;

  // Reference model state
  logic [47:0] acc   [NI];
  bit          ovf_m [NI];
  bit          chain [NI];
  int unsigned cnt   [NI];
  logic [48:0] exp_q [$];

  // Observed results and per-cycle trace (written only by the monitor)
  logic [48:0] got_q [$];
  int          got_rd = 0;
  bit          tr_acc [$];
  logic [7:0]  tr_op  [$];
  bit          tr_ov  [$];
  int          tr_k = 0;

  function automatic int unsigned nt(int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 1024;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_inst
    localparam int unsigned NTaps = (g == 0) ? 4 : (g == 1) ? 1 : 1024;
    // Slice model: A1REG/B1REG, MREG, OPMODEREG, PREG and CARRYOUTREG, no reset.
    logic [17:0] a1  = '0;
    logic [17:0] b1  = '0;
    logic [35:0] m   = '0;
    logic [7:0]  opr = '0;
    logic [47:0] p   = '0;
    logic        co  = 1'b0;
    logic [47:0] xm, zm;
    logic [48:0] sum;

    always_comb begin
      xm = '0;
      case (opr[1:0])
        2'b01:   xm = {12'b0, m};
        2'b10:   xm = p;
        default: xm = '0;
      endcase
      zm  = (opr[3:2] == 2'b10) ? p : '0;
      sum = {1'b0, xm} + {1'b0, zm};
    end

    always @(posedge clk) begin
      a1  <= dsp_a[g];
      b1  <= dsp_b[g];
      m   <= 36'(a1) * 36'(b1);
      opr <= op_force[g] ? (dsp_op[g] | 8'h08) : dsp_op[g];
      if (pre_en[g]) begin
        p  <= pre_val;
        co <= 1'b0;
      end else begin
        p  <= sum[47:0];
        co <= sum[48];
      end
    end

    assign dsp_p[g]    = p;
    assign dsp_cout[g] = co;

    dsp_mac_sequencer #(
      .N_TAPS    (NTaps),
      .P_LAT     (3),
      .OPMODE_DLY(1)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .in_a         (in_a[g]),
      .in_b         (in_b[g]),
      .dsp_a        (dsp_a[g]),
      .dsp_b        (dsp_b[g]),
      .dsp_opmode   (dsp_op[g]),
      .dsp_p        (dsp_p[g]),
      .dsp_carry_out(dsp_cout[g]),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g]),
      .out_data     (out_data[g]),
      .out_ovf      (out_ovf[g])
    );
  end

  // Monitor: sampled on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        if (out_valid[k] && out_ready[k]) got_q.push_back({out_ovf[k], out_data[k]});
      end
    end
    tr_acc.push_back(in_valid[tr_k] && in_ready[tr_k]);
    tr_op.push_back(dsp_op[tr_k]);
    tr_ov.push_back(out_valid[tr_k]);
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(int k, logic [17:0] a, logic [17:0] b);
    logic [35:0] prod;
    logic [48:0] s;
    prod = 36'(a) * 36'(b);
    if (cnt[k] == 0 && !chain[k]) begin
      acc[k]   = 48'(prod);
      ovf_m[k] = 1'b0;
    end else begin
      s        = {1'b0, acc[k]} + 49'(prod);
      ovf_m[k] = ovf_m[k] | s[48];
      acc[k]   = s[47:0];
    end
    chain[k] = 1'b0;
    cnt[k]++;
    if (cnt[k] == nt(k)) begin
      exp_q.push_back({ovf_m[k], acc[k]});
      cnt[k] = 0;
    end
  endtask

  task automatic send(int k, logic [17:0] a, logic [17:0] b);
    bit ok;
    ok          = 1'b0;
    last_wait   = 0;
    in_valid[k] = 1'b1;
    in_a[k]     = a;
    in_b[k]     = b;
    while (!ok && last_wait < 300) begin
      @(negedge clk);
      ok = in_ready[k];
      last_wait++;
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b0;
    chk($sformatf("accept_k%0d", k), 64'(ok), 64'd1);
    if (ok) model_accept(k, a, b);
  endtask

  task automatic drain(string tag);
    int w;
    w = 0;
    while ((got_q.size() - got_rd) < exp_q.size() && w < 3000) begin
      @(posedge clk);
      w++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_count"}, 64'(got_q.size() - got_rd), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_rd + i < got_q.size()) chk($sformatf("%s_res%0d", tag, i), 64'(got_q[got_rd + i]),
                                         64'(exp_q[i]));
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  // Each sampled cycle i implies the OPMODE seen two samples later.
  task automatic check_ops(string tag, int k, int base, int unsigned tap0);
    int unsigned tap;
    logic [7:0]  e, o, fe, fo;
    bit          bad;
    tap = tap0;
    bad = 1'b0;
    fe  = 8'hff;
    fo  = 8'h00;
    for (int i = base; i + 2 < tr_op.size(); i++) begin
      e = tr_acc[i] ? ((tap == 0) ? 8'h01 : 8'h09) : 8'h08;
      o = tr_op[i + 2];
      if (!bad) begin
        fe = e;
        fo = o;
      end
      if (o !== e) bad = 1'b1;
      if (tr_acc[i]) tap = (tap + 1 == nt(k)) ? 0 : tap + 1;
    end
    chk(tag, 64'(fo), 64'(fe));
  endtask

  task automatic check_zero(string tag, int k);
    chk($sformatf("%s_dsp_a_k%0d", tag, k), 64'(dsp_a[k]), 64'd0);
    chk($sformatf("%s_dsp_b_k%0d", tag, k), 64'(dsp_b[k]), 64'd0);
    chk($sformatf("%s_opmode_k%0d", tag, k), 64'(dsp_op[k]), 64'd0);
    chk($sformatf("%s_out_valid_k%0d", tag, k), 64'(out_valid[k]), 64'd0);
    chk($sformatf("%s_out_data_k%0d", tag, k), 64'(out_data[k]), 64'd0);
    chk($sformatf("%s_out_ovf_k%0d", tag, k), 64'(out_ovf[k]), 64'd0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      cnt[k]   = 0;
      chain[k] = 1'b0;
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  initial begin
    int  base, j;
    bit  done;
    rst_n   = 1'b0;
    pre_val = '0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      in_a[k]      = '0;
      in_b[k]      = '0;
      out_ready[k] = 1'b1;
      pre_en[k]    = 1'b0;
      op_force[k]  = 1'b0;
      acc[k]       = '0;
      ovf_m[k]     = 1'b0;
    end
    model_reset();

    #12;
    for (int k = 0; k < NI; k++) begin
      check_zero("reset", k);
      chk($sformatf("reset_in_ready_k%0d", k), 64'(in_ready[k]), 64'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back dot product of four pairs
    tr_k = 0;
    base = tr_op.size();
    send(0, 18'd1, 18'd2);
    send(0, 18'd3, 18'd4);
    send(0, 18'd5, 18'd6);
    send(0, 18'd7, 18'd8);
    drain("dot4");
    check_ops("dot4_opmode", 0, base, 0);
    j = -1;
    for (int i = base; i < tr_acc.size(); i++) if (tr_acc[i]) j = i;
    chk("dot4_ov_early", 64'(tr_ov[j + 4]), 64'd0);
    chk("dot4_ov_rise", 64'(tr_ov[j + 5]), 64'd1);
    chk("dot4_ov_fall", 64'(tr_ov[j + 6]), 64'd0);

    // Three idle cycles between pairs 2 and 3
    base = tr_op.size();
    send(0, 18'd1, 18'd2);
    send(0, 18'd3, 18'd4);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    send(0, 18'd5, 18'd6);
    send(0, 18'd7, 18'd8);
    drain("gap");
    check_ops("gap_opmode", 0, base, 0);

    // Two results with the consumer stalled until cycle 20
    base = tr_op.size();
    out_ready[0] = 1'b0;
    fork
      begin
        repeat (20) @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
      begin
        for (int i = 0; i < 4; i++) send(0, 18'd1, 18'd1);
        for (int i = 0; i < 3; i++) send(0, 18'd2, 18'd2);
        send(0, 18'd2, 18'd2);
        chk("b2b_pair8_stalled", 64'(last_wait > 1), 64'd1);
      end
    join
    drain("b2b");
    check_ops("b2b_opmode", 0, base, 0);

    // Asynchronous reset in the middle of a result
    send(0, 18'd1, 18'd2);
    send(0, 18'd3, 18'd4);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_zero("midrst", 0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("midrst_hold", 0);
    rst_n = 1'b1;
    base  = tr_op.size();
    send(0, 18'd1, 18'd2);
    send(0, 18'd3, 18'd4);
    send(0, 18'd5, 18'd6);
    send(0, 18'd7, 18'd8);
    drain("postrst");
    check_ops("postrst_opmode", 0, base, 0);

    // Randomized pairs, gaps and consumer backpressure
    base = tr_op.size();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(0, 18'($urandom), 18'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready[0] = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready[0] = 1'b1;
    drain("rand");
    check_ops("rand_opmode", 0, base, 0);

    // N_TAPS=1: every pair is its own result
    tr_k = 1;
    base = tr_op.size();
    send(1, 18'h3FFFF, 18'h3FFFF);
    send(1, 18'd2, 18'd3);
    drain("ntaps1");
    check_ops("ntaps1_opmode", 1, base, 0);

    // N_TAPS=1024 accumulating from a preloaded P near the 48-bit wrap
    op_force[2] = 1'b1;
    pre_val     = 48'hFFFF_FFFF_F000;
    pre_en[2]   = 1'b1;
    @(posedge clk);
    #1;
    pre_en[2] = 1'b0;
    acc[2]    = pre_val;
    ovf_m[2]  = 1'b0;
    chain[2]  = 1'b1;
    for (int i = 0; i < 64; i++) send(2, 18'h3FFFF, 18'h3FFFF);
    for (int i = 64; i < 1024; i++) send(2, 18'($urandom), 18'($urandom));
    chk("wrap_model_ovf", 64'(exp_q.size() == 1 && exp_q[0][48]), 64'd1);
    drain("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Drives one DSP48A1 slice as a multiply-accumulate engine. Takes a valid/ready stream of unsigned 18-bit operand pairs and returns one 48-bit dot-product result for every N_TAPS pairs.
- Issues A/B and a per-cycle OPMODE to the slice, and tracks the slice pipeline with a tag shift register.
- Captures P and CARRY_OUT into a one-entry output buffer with valid/ready handshake.
- The slice is instanced with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYOUTREG=1, B_INPUT="DIRECT" and CARRYINSEL="OPMODE5".
- The sequencer holds the slice CE inputs at 1 and its RST inputs at 0.

Parameters:
- N_TAPS, 8: operand pairs per result; legal range 1 to 1024.
- P_LAT, 3: cycles from operand issue (cycle t) until DSP_P/DSP_CARRY_OUT reflect that operand (cycle t+P_LAT).
- OPMODE_DLY, 1: cycles between issuing an operand pair and issuing its OPMODE.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  sequencer accepts the pair this cycle.
- IN_A  in  18  unsigned multiplicand.
- IN_B  in  18  unsigned multiplier.
- DSP_A  out  18  to slice A.
- DSP_B  out  18  to slice B.
- DSP_OPMODE  out  8  to slice OPMODE.
- DSP_P  in  48  from slice P.
- DSP_CARRY_OUT  in  1  from slice CARRY_OUT.
- OUT_VALID  out  1  result buffer holds a result.
- OUT_READY  in  1  consumer takes the result.
- OUT_DATA  out  48  accumulated result.
- OUT_OVF  out  1  a carry-out occurred during accumulation of this result.

Behaviour:
- Reset (RST_N low, asynchronous): all registered outputs go to 0. This covers DSP_A, DSP_B, DSP_OPMODE, OUT_VALID, OUT_DATA and OUT_OVF. It also clears the tap counter, tag pipe, sticky overflow flag and OPMODE delay line.
- Reset mid-operation discards partial sums and all in-flight results. The first pair accepted after reset is tap 0.
- Accept occurs when IN_VALID && IN_READY. The sequencer registers IN_A/IN_B onto DSP_A/DSP_B at the accept edge.
- DSP_A/DSP_B are don't-care on non-accept cycles; the implementation holds their last value.
- Tap counter: 0..N_TAPS-1, increments on each accept and wraps to 0 after tap N_TAPS-1 (the "last" tap).
- OPMODE codes, using slice X/Z encoding (X: 00=0, 01=M, 10=P; Z: 00=0, 10=P; bits 7:4 always 0):
  - tap 0: 0x01 (P = M).
  - taps 1..N_TAPS-1: 0x09 (P = P + M).
  - non-accept cycle: 0x08 (P = P, hold).
  - N_TAPS=1: every tap uses 0x01.
- The OPMODE for an accept at cycle t appears on DSP_OPMODE at cycle t+OPMODE_DLY, via a delay line of OPMODE_DLY registers. Bubble codes enter the same line.
- Back-to-back accepts every cycle are legal. The feedback P is valid in time at P_LAT=3.
- Tag pipe: P_LAT-deep shift of {valid, last}, loaded on each accept.
  - When a valid tag exits, DSP_CARRY_OUT is ORed into a sticky overflow bit.
  - When a valid tag with last=1 exits, the buffer loads DSP_P into OUT_DATA and sticky|DSP_CARRY_OUT into OUT_OVF, sets OUT_VALID, and clears sticky.
- Output buffer: OUT_VALID is cleared on OUT_VALID && OUT_READY unless a load happens in the same cycle. If a load coincides with a pop, the new result loads and OUT_VALID stays 1.
- IN_READY is combinational:
  - For non-last taps, IN_READY = 1.
  - For the last tap, IN_READY = (no last tag in tag pipe) && (!OUT_VALID || OUT_READY).
  - This guarantees the buffer never overwrites an unconsumed result.
- IN_READY never depends on IN_VALID.
- Latency: last-tap accept at cycle t gives OUT_VALID=1 at cycle t+P_LAT+1.
- Arithmetic: the product is 36-bit unsigned and the accumulation is 48-bit modulo 2^48, with overflow reported via OUT_OVF.

Test Plan:
- N_TAPS=4; pairs (1,2),(3,4),(5,6),(7,8) streamed back-to-back with OUT_READY=1 -> OUT_DATA=100 (0x64) and OUT_OVF=0. OUT_VALID rises 4 cycles after the 4th accept and is high 1 cycle. DSP_OPMODE sequence is 01,09,09,09.
- Same pairs with IN_VALID low for 3 cycles between pairs 2 and 3 -> 0x08 issued during the gap, OUT_DATA still 100.
- Two results back-to-back ((1,1)x4 then (2,2)x4) with OUT_READY=0 until the 20th cycle -> IN_READY low on the 8th pair until the first result pops. Outputs are 4 then 16, none lost or duplicated.
- Async reset asserted after the 2nd pair, then released and pairs (1,2),(3,4),(5,6),(7,8) applied -> all outputs 0 during reset, then the result is 100, with no stale contribution.
- N_TAPS=1, pairs (0x3FFFF,0x3FFFF) and (2,3) -> OUT_DATA 0xFFFF80001 then 6. OPMODE is 0x01 for both.
- With OPMODE[7:0] forced to drive subtract-free accumulation near wrap: 64 pairs of (0x3FFFF,0x3FFFF) with N_TAPS=1024 and P preloaded to 0xFFFF_FFFF_F000 via a bench slice force -> OUT_OVF=1 and OUT_DATA equals the modulo-2^48 sum.
